// File: rtl/instr_fetch_pkg.sv
// Shared decode definitions: next-PC select encodings, reset vector, ALU encodings
// and the fetch FSM state type.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      NPC_PLUS4  = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JUMP   = 2'b10,
      NPC_JR     = 2'b11
   } npc_op_e;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_NOR  = 4'h5,
      ALU_SLT  = 4'h6,
      ALU_SLTU = 4'h7,
      ALU_SLL  = 4'h8,
      ALU_SRL  = 4'h9,
      ALU_SRA  = 4'hA,
      ALU_LUI  = 4'hB
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10,
      S_HOLD = 2'b11
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_npc.sv
// Combinational next-PC selection: sequential, PC-relative branch, pseudo-direct
// jump and register jump. All arithmetic wraps modulo 2^32.
module npc
   import instr_fetch_pkg::*;
(
   input  logic [31:0] pc_i,
   input  npc_op_e     op_i,
   input  logic [15:0] imm16_i,
   input  logic [25:0] jtarget_i,
   input  logic [31:0] regrs_i,
   output logic [31:0] npc_o
);

   logic [31:0] pc_plus4;
   logic [31:0] br_off;

   assign pc_plus4 = pc_i + 32'd4;
   assign br_off   = {{14{imm16_i[15]}}, imm16_i, 2'b00};

   always_comb begin
      npc_o = pc_plus4;
      unique case (op_i)
         NPC_PLUS4:  npc_o = pc_plus4;
         NPC_BRANCH: npc_o = pc_plus4 + br_off;
         NPC_JUMP:   npc_o = {pc_plus4[31:28], jtarget_i, 2'b00};
         NPC_JR:     npc_o = regrs_i & ~32'h3;
         default:    npc_o = pc_plus4;
      endcase
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem request, holds the fetched word for
// the decoder. Define NPC_LINK_EN to add the LinkAddr (PC+4) output.
module instr_fetch
   import instr_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   output logic [31:0] IAddr,
   output logic        IReq,
   input  logic        IGnt,
   input  logic [31:0] IRdata,
   input  logic        IRvalid,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic        InstrValid,
   input  logic        InstrReady,
   input  logic [1:0]  NPCOp,
   input  logic [15:0] Imm16,
   input  logic [25:0] JTarget,
`ifdef NPC_LINK_EN
   input  logic [31:0] RegRS,
   output logic [31:0] LinkAddr
`else
   input  logic [31:0] RegRS
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  npc_val;

   npc u_npc (
      .pc_i      (pc_q),
      .op_i      (npc_op_e'(NPCOp)),
      .imm16_i   (Imm16),
      .jtarget_i (JTarget),
      .regrs_i   (RegRS),
      .npc_o     (npc_val)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // IRvalid is only honoured in WAIT, so stale responses after reset are dropped
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      IReq       = 1'b0;
      InstrValid = 1'b0;
      unique case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            IReq = 1'b1;
            if (IGnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (IRvalid) begin
               instr_d = IRdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            InstrValid = 1'b1;
            if (InstrReady) begin
               pc_d    = npc_val;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign IAddr = pc_q;
   assign PC    = pc_q;
   assign Instr = instr_q;

`ifdef NPC_LINK_EN
   assign LinkAddr = InstrValid ? (pc_q + 32'd4) : '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: randomized imem/decoder stimulus against an
// arithmetic next-PC model, with directed vectors for the documented corner cases.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic        clk  = 1'b0;
   logic        rstn = 1'b1;
   logic [31:0] IAddr;
   logic        IReq;
   logic        IGnt = 1'b0;
   logic [31:0] IRdata = '0;
   logic        IRvalid = 1'b0;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic        InstrValid;
   logic        InstrReady = 1'b0;
   logic [1:0]  NPCOp = '0;
   logic [15:0] Imm16 = '0;
   logic [25:0] JTarget = '0;
   logic [31:0] RegRS = '0;
`ifdef NPC_LINK_EN
   logic [31:0] LinkAddr;
`endif

   instr_fetch dut (
      .clk        (clk),
      .rstn       (rstn),
      .IAddr      (IAddr),
      .IReq       (IReq),
      .IGnt       (IGnt),
      .IRdata     (IRdata),
      .IRvalid    (IRvalid),
      .Instr      (Instr),
      .PC         (PC),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .NPCOp      (NPCOp),
      .Imm16      (Imm16),
      .JTarget    (JTarget),
`ifdef NPC_LINK_EN
      .RegRS      (RegRS),
      .LinkAddr   (LinkAddr)
`else
      .RegRS      (RegRS)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          hold_edge;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] addr_q[$];
   int          tests = 0;
   int          fails = 0;
   int          edges = 0;

   always @(posedge clk) begin
      if (!rstn) edges <= 0;
      else       edges <= edges + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got unexpected event expected none (t=%0t)", name, $time);
   endtask

   function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [1:0] op,
                                           input logic [15:0] imm, input logic [25:0] jt,
                                           input logic [31:0] rs);
      logic [31:0] seq;
      int          off;
      seq = pc + 32'd4;
      off = int'($signed(imm)) * 4;
      case (op)
         2'd0:    return seq;
         2'd1:    return seq + 32'(off);
         2'd2:    return (seq & 32'hF000_0000) | (32'(jt) * 32'd4);
         default: return (rs / 32'd4) * 32'd4;
      endcase
   endfunction

   // Monitor: reset values, grant addresses, captured words and hold stability
   logic        m_prev_iv = 1'b0;
   logic [31:0] h_pc = '0;
   logic [31:0] h_instr = '0;
   exp_t        m_e;

   always @(negedge clk) begin
      if (!rstn) begin
         check("rst_pc", PC, RST_PC);
         check("rst_instr", Instr, 32'h0);
         check("rst_ireq", 32'(IReq), 32'h0);
         check("rst_valid", 32'(InstrValid), 32'h0);
         m_prev_iv = 1'b0;
      end else begin
         if (IReq && IGnt) begin
            if (addr_q.size() == 0) fail_now("iaddr_unexpected_req");
            else check("iaddr", IAddr, addr_q.pop_front());
         end
         if (InstrValid && !m_prev_iv) begin
            if (exp_q.size() == 0) fail_now("hold_unexpected");
            else begin
               m_e = exp_q.pop_front();
               check("cap_instr", Instr, m_e.instr);
               check("cap_pc", PC, m_e.pc);
               if (m_e.hold_edge >= 0) check("hold_cycle", 32'(edges), 32'(m_e.hold_edge));
               h_pc    = m_e.pc;
               h_instr = m_e.instr;
            end
         end else if (InstrValid) begin
            check("hold_instr", Instr, h_instr);
            check("hold_pc", PC, h_pc);
            check("hold_noreq", 32'(IReq), 32'h0);
         end
`ifdef NPC_LINK_EN
         check("link", LinkAddr, InstrValid ? h_pc + 32'd4 : 32'h0);
`endif
         m_prev_iv = InstrValid;
      end
   end

   // Directed consume vectors for the first instructions after power-up
   logic [1:0]  d_op  [6] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00};
   logic [15:0] d_imm [6] = '{16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0};
   logic [25:0] d_jt  [6] = '{26'h0000C05, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0};
   logic [31:0] d_rs  [6] = '{32'h0, 32'h0000_3023, 32'h0000_3008, 32'h0,
                              32'hFFFF_FFFF, 32'h0};

   initial begin
      bit          pending, resp_driven, did_reset, prev_ireq, prev_iv;
      int          lat, captured, cur, bp, total, late;
      logic [31:0] model_pc;
      pending = 0; resp_driven = 0; did_reset = 0; prev_ireq = 0; prev_iv = 0;
      lat = 0; captured = 0; cur = -1; bp = 0; total = 0; late = 0;

      #2 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn     = 1'b1;
      model_pc = RST_PC;
      addr_q.push_back(model_pc);

      for (int cyc = 0; cyc < 5000 && total < 100; cyc++) begin
         @(posedge clk);
         #1;
         // Outcome of the edge just taken, from the inputs driven last slot
         if (prev_ireq && IGnt) begin
            pending = 1;
            lat     = (captured == 0) ? 0 : $urandom_range(0, 3);
         end else if (resp_driven) begin
            pending = 0;
            exp_q.push_back('{model_pc, IRdata, (captured == 0 && !did_reset) ? 3 : -1});
            cur = captured;
            captured++;
            total++;
            bp = 0;
         end else if (prev_iv && InstrReady) begin
            model_pc = ref_npc(model_pc, NPCOp, Imm16, JTarget, RegRS);
            addr_q.push_back(model_pc);
         end

         if (!did_reset && total >= 40 && pending && lat > 1) begin
            rstn = 1'b0; IGnt = 1'b0; IRvalid = 1'b0; InstrReady = 1'b0;
            pending = 0; resp_driven = 0;
            repeat (2) begin
               @(posedge clk);
               #1;
            end
            IRvalid   = 1'b1;
            IRdata    = 32'hDEAD_BEEF;
            rstn      = 1'b1;
            did_reset = 1;
            captured  = 0;
            cur       = -1;
            late      = 2;
            exp_q.delete();
            addr_q.delete();
            model_pc  = RST_PC;
            addr_q.push_back(model_pc);
            prev_ireq = 0;
            prev_iv   = 0;
            continue;
         end

         prev_ireq   = IReq;
         prev_iv     = InstrValid;
         resp_driven = 0;
         IRvalid     = 1'b0;
         IRdata      = $urandom;
         if (late > 0) begin
            IGnt    = 1'b0;
            IRvalid = 1'b1;
            late--;
         end else begin
            IGnt = IReq && ((captured == 0) || ($urandom_range(0, 2) != 0));
            if (pending) begin
               if (lat == 0) begin
                  IRvalid     = 1'b1;
                  resp_driven = 1;
                  if (captured == 0 && !did_reset) IRdata = 32'h2008_0005;
               end else lat--;
            end else begin
               IRvalid = ($urandom_range(0, 3) == 0);
            end
         end

         if (InstrValid && !did_reset && cur >= 0 && cur < 6) begin
            NPCOp      = d_op[cur];
            Imm16      = d_imm[cur];
            JTarget    = d_jt[cur];
            RegRS      = d_rs[cur];
            InstrReady = !(cur == 3 && bp < 5);
            if (cur == 3) begin
               if (bp == 2) IRvalid = 1'b1;
               else         IRvalid = 1'b0;
               bp++;
            end
         end else begin
            NPCOp      = 2'($urandom_range(0, 3));
            Imm16      = 16'($urandom);
            JTarget    = 26'($urandom);
            RegRS      = $urandom;
            InstrReady = ($urandom_range(0, 2) == 0);
         end
      end

      check("instr_count", 32'(total >= 100), 32'h1);
      check("reset_in_wait_done", 32'(did_reset), 32'h1);
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
